// File: rtl/rmii_pkg.sv
// Shared types and dibit encodings for the RMII receive path.
package rmii_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [1:0] DIBIT_LEAD = 2'b00;
    localparam logic [1:0] DIBIT_PRE  = 2'b01;
    localparam logic [1:0] DIBIT_SFD  = 2'b11;

endpackage

// File: rtl/rmii_byte_assembler.sv
// Packs LSB-first dibits into bytes; byte_vld pulses the cycle after the 4th dibit.
module rmii_byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dibit_vld,
    input  logic [1:0] dibit,
    output logic       byte_vld,
    output logic [7:0] byte_out,
    output logic [1:0] phase
);

    // Only the first three dibits need holding; the fourth goes straight into byte_out.
    logic [5:0] low_bits;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            phase    <= 2'd0;
            byte_vld <= 1'b0;
            low_bits <= 6'd0;
            byte_out <= 8'd0;
        end else if (clr) begin
            phase    <= 2'd0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= dibit_vld && (phase == 2'd3);
            if (dibit_vld) begin
                phase <= phase + 2'd1;
                case (phase)
                    2'd0:    low_bits[1:0] <= dibit;
                    2'd1:    low_bits[3:2] <= dibit;
                    2'd2:    low_bits[5:4] <= dibit;
                    default: byte_out      <= {dibit, low_bits};
                endcase
            end
        end
    end

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD hunt, byte assembly, and start/end/error marking.
module rmii_rx_framer
    import rmii_pkg::*;
#(
    parameter int MIN_PREAMBLE_DIBITS = 8,
    parameter int MAX_FRAME_BYTES     = 1518,
    parameter int CNT_W               = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crs_dv,
    input  logic [1:0]       rx_data,
    input  logic             rx_err,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_err,
    output logic [CNT_W-1:0] out_len
);

    localparam int               PRE_W   = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PREAMBLE_DIBITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BYTES);

    rx_state_t        state, state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             err;
    logic             byte_ok;
    logic             first_q;
    logic             sfd_ok;
    logic             dibit_vld;
    logic             byte_done;
    logic             byte_vld;
    logic [7:0]       byte_out;
    logic [1:0]       phase;

    assign sfd_ok    = (state == PREAMBLE) && crs_dv && (rx_data == DIBIT_SFD) && (pre_cnt >= PRE_MIN);
    assign dibit_vld = (state == DATA) && crs_dv;
    assign byte_done = dibit_vld && (phase == 2'd3);

    rmii_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (sfd_ok),
        .dibit_vld (dibit_vld),
        .dibit     (rx_data),
        .byte_vld  (byte_vld),
        .byte_out  (byte_out),
        .phase     (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DROP;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            DROP:     if (!crs_dv) state_nxt = IDLE;
            IDLE: begin
                if (crs_dv) begin
                    if (rx_data == DIBIT_PRE)       state_nxt = PREAMBLE;
                    else if (rx_data != DIBIT_LEAD) state_nxt = DROP;
                end
            end
            PREAMBLE: begin
                if (!crs_dv)                    state_nxt = IDLE;
                else if (sfd_ok)                state_nxt = DATA;
                else if (rx_data != DIBIT_PRE)  state_nxt = DROP;
            end
            DATA:     if (!crs_dv) state_nxt = IDLE;
            default:  state_nxt = DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
            byte_ok  <= 1'b0;
            first_q  <= 1'b0;
            out_eof  <= 1'b0;
            out_err  <= 1'b0;
            out_len  <= '0;
        end else begin
            out_eof <= 1'b0;
            out_err <= 1'b0;
            out_len <= '0;

            if (state == IDLE && crs_dv && rx_data == DIBIT_PRE)
                pre_cnt <= PRE_W'(1);
            else if (state == PREAMBLE && crs_dv && rx_data == DIBIT_PRE && pre_cnt < PRE_MIN)
                pre_cnt <= pre_cnt + PRE_W'(1);

            if (sfd_ok) begin
                byte_cnt <= '0;
                err      <= 1'b0;
            end
            if (dibit_vld && rx_err) err <= 1'b1;

            // Counting stops at MAX+1 so out_len reports one past the limit on oversize frames.
            if (byte_done) begin
                byte_ok <= (byte_cnt < CNT_MAX);
                first_q <= (byte_cnt == '0);
                if (byte_cnt <= CNT_MAX) byte_cnt <= byte_cnt + CNT_W'(1);
                if (byte_cnt == CNT_MAX) err <= 1'b1;
            end

            if (state == DATA && !crs_dv) begin
                out_eof <= 1'b1;
                out_len <= byte_cnt;
                out_err <= err | (phase != 2'd0) | (byte_cnt == '0);
            end
        end
    end

    assign out_data  = byte_out;
    assign out_valid = byte_vld & byte_ok;
    assign out_sof   = out_valid & first_q;

endmodule

// File: doc/rmii_rx_framer.md
Name: rmii_rx_framer

Overview:
Receive-side framer for the RMII port, the stage downstream of the wire our frame-blasting TX MAC drives. It samples crs_dv/rx_data every clk (50 MHz, 100 Mbps), hunts preamble and SFD, and assembles dibits into bytes. It emits a byte stream with start/end/error markers for the switch fabric.

Parameters:
MIN_PREAMBLE_DIBITS, 8, minimum consecutive 01 dibits before the SFD dibit 11 is accepted
MAX_FRAME_BYTES, 1518, payload bytes after SFD beyond which the frame is marked bad and dropped
CNT_W, 11, width of byte counter and out_len (must hold MAX_FRAME_BYTES+1)

Ports:
clk  in  1  RMII reference clock; all logic on posedge
rst  in  1  synchronous, active-high reset
crs_dv  in  1  carrier sense / data valid from PHY
rx_data  in  2  received dibit
rx_err  in  1  PHY receive error
out_data  out  8  assembled byte
out_valid  out  1  out_data valid, single-cycle pulse per byte
out_sof  out  1  high with out_valid on first byte of frame
out_eof  out  1  single-cycle end-of-frame pulse (out_valid=0 that cycle)
out_err  out  1  frame status, valid only while out_eof=1
out_len  out  CNT_W  bytes delivered in the frame, valid only while out_eof=1

Behaviour:
- Reset: out_valid/out_sof/out_eof/out_err=0, out_data=0, out_len=0; state=DROP; counters and err flag cleared. Reset mid-frame emits no eof; the frame is abandoned silently.
- States: IDLE, PREAMBLE, DATA, DROP.
- DROP: ignore input; crs_dv=0 -> IDLE. Guarantees no mid-frame lock after reset.
- IDLE: crs_dv=1 & rx_data=01 -> PREAMBLE, pre_cnt=1. crs_dv=1 & 00 -> stay (PHY preamble lead-in). crs_dv=1 & (10|11) -> DROP.
- PREAMBLE: crs_dv=0 -> IDLE. 01 -> pre_cnt++ (saturating). 11 & pre_cnt>=MIN_PREAMBLE_DIBITS -> DATA, phase=0, byte_cnt=0, err=0. 11 & pre_cnt<MIN -> DROP. 00|10 -> DROP.
- DATA, crs_dv=1: the dibit is written to shift bits [2*phase+1 : 2*phase] (LSB first: first dibit -> bits[1:0]); phase wraps 3->0. On phase=3 the next cycle has out_data = completed byte, out_valid=1, out_sof=1 if byte_cnt was 0; byte_cnt++.
- rx_err=1 with crs_dv=1 in DATA -> err sticky.
- byte_cnt reaching MAX_FRAME_BYTES+1 -> err=1; further bytes are not emitted; state stays DATA (silent) until crs_dv=0.
- DATA, crs_dv=0: the next cycle has out_eof=1, out_len=byte_cnt, out_err = err | (phase!=0) | (byte_cnt==0); then IDLE. Partial-byte dibits are discarded.
- Byte completion and eof never share a cycle: out_valid follows a crs_dv=1 sample, out_eof follows a crs_dv=0 sample.
- Latency: 1 cycle from the 4th dibit sample to out_valid.
- No toggling-CRS tolerance: a single crs_dv=0 sample ends the frame.
- rx_err outside DATA is ignored.

Decomposition:
- Package rmii_pkg: rx_state_t enum (IDLE, PREAMBLE, DATA, DROP), constants DIBIT_PRE=2'b01, DIBIT_SFD=2'b11.
- Sub-module rmii_byte_assembler: phase counter plus 8-bit shift register with load/clear. Ports: clk, rst, clr, dibit_vld, dibit, byte_vld, byte_out, phase. The top FSM owns framing, counters and status.

Test Plan:
- Good frame: reset, crs_dv=0 for 2 cycles, then 31×01, 11, dibits 10,10,00,11, 01,00,00,00, crs_dv=0. Required: out_data=0xCA with sof=1; then 0x01 with sof=0; then eof, out_len=2, out_err=0.
- Short preamble: 5×01 then 11 (MIN=8). Required: DROP, no out_valid, no eof; the following good frame is received normally.
- Misaligned end: SFD, 6 dibits, crs_dv=0. Required: one byte out, then eof, out_len=1, out_err=1.
- rx_err: pulse rx_err on the 2nd data dibit of a 3-byte frame. Required: all 3 bytes emitted, eof out_err=1, out_len=3.
- Oversize: MAX_FRAME_BYTES=4, send 6 bytes. Required: exactly 4 out_valid pulses, eof out_len=5, out_err=1.
- Reset mid-frame: assert rst after byte 1 while crs_dv stays high with data containing 01/11 dibits. Required: outputs 0, no eof, no lock until crs_dv=0; next frame good.
